debounce_timer_arbiter: RTL and testbench

Multi-channel switch debouncer in which N_CH per-channel FSMs share one delay timer instead of one counter per switch. A round-robin arbiter grants the timer to one channel at a time and sequences its lockout interval. It sits between raw board switches and the user logic that consumes the one-shot pulses. It replaces per-switch debouncer and delay-counter pairs where many inputs exist.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_channel_fsm.sv | 98 +++++++++
 rtl/debounce_timer_arbiter.sv | 110 +++++++++++
 tb/tb_debounce_timer_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types for the debounced switch block: per-channel state codes and
// a helper that gives the narrowest timer able to reach a lockout length.
package debounce_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        SHOT   = 3'b001,
        WAIT_P = 3'b011,
        HELD   = 3'b010,
        WAIT_R = 3'b110
    } state_e;

    // Smallest width w with 2**w >= delay.
    function automatic int min_cnt_w(input int delay);
        int w;
        w = 1;
        while ((1 << w) < delay) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel_fsm.sv
// One switch channel: 2-flop synchronizer plus press/release FSM that asks the
// shared timer for a lockout. RELEASE_SHOT_EN adds a release pulse output.
module debounce_channel_fsm
    import debounce_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    input  logic done_i,
    output logic req_o,
    output logic one_shot_o,
    output logic level_o
`ifdef RELEASE_SHOT_EN
    ,
    output logic release_shot_o
`endif
);

    logic [1:0] sync_q;
    state_e     state_q;
    logic       req_q;
    logic       one_shot_q;
    logic       level_q;
`ifdef RELEASE_SHOT_EN
    logic       release_q;
`endif
    logic       sw_s;

    assign sw_s = sync_q[1];

    // Outputs are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            req_q      <= 1'b0;
            one_shot_q <= 1'b0;
            level_q    <= 1'b0;
`ifdef RELEASE_SHOT_EN
            release_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], sw_i};
            one_shot_q <= 1'b0;
`ifdef RELEASE_SHOT_EN
            release_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (sw_s) begin
                        state_q    <= SHOT;
                        one_shot_q <= 1'b1;
                        level_q    <= 1'b1;
                    end
                end
                SHOT: begin
                    state_q <= WAIT_P;
                    req_q   <= 1'b1;
                end
                WAIT_P: begin
                    if (done_i) begin
                        state_q <= HELD;
                        req_q   <= 1'b0;
                    end
                end
                HELD: begin
                    if (!sw_s) begin
                        state_q   <= WAIT_R;
                        req_q     <= 1'b1;
                        level_q   <= 1'b0;
`ifdef RELEASE_SHOT_EN
                        release_q <= 1'b1;
`endif
                    end
                end
                WAIT_R: begin
                    if (done_i) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_o      = req_q;
    assign one_shot_o = one_shot_q;
    assign level_o    = level_q;
`ifdef RELEASE_SHOT_EN
    assign release_shot_o = release_q;
`endif

endmodule

// File: rtl/debounce_timer_arbiter.sv
// N_CH switch debouncers sharing one lockout timer, handed out round-robin.
// Define RELEASE_SHOT_EN to add the per-channel release_shot output.
module debounce_timer_arbiter
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DELAY_CYCLES = 50000,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sw,
    output logic [N_CH-1:0]         one_shot,
    output logic [N_CH-1:0]         level,
    output logic                    busy,
    output logic [$clog2(N_CH)-1:0] grant_id
`ifdef RELEASE_SHOT_EN
    ,
    output logic [N_CH-1:0]         release_shot
`endif
);

    localparam int ID_W = $clog2(N_CH);

    if (CNT_W < min_cnt_w(DELAY_CYCLES)) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for DELAY_CYCLES");
    end

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  req_eff;
    logic             busy_q;
    logic [ID_W-1:0]  gnt_q;
    logic [ID_W-1:0]  ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done;
    logic             free;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  idx;
    int               cand;

    assign done = busy_q && (cnt_q == CNT_W'(DELAY_CYCLES - 1));
    assign free = !busy_q || done;

    // The finishing owner still shows req this cycle; mask it so it cannot re-win.
    // Scanning from the far end lets the requester closest to the pointer win.
    always_comb begin
        req_eff = req;
        if (done) begin
            req_eff[gnt_q] = 1'b0;
        end
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            idx = ID_W'(cand);
            if (req_eff[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            gnt_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else if (free) begin
            cnt_q <= '0;
            if (win_found) begin
                busy_q <= 1'b1;
                gnt_q  <= win_id;
                ptr_q  <= (win_id == ID_W'(N_CH - 1)) ? '0 : win_id + 1'b1;
            end else begin
                busy_q <= 1'b0;
                gnt_q  <= '0;
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign busy     = busy_q;
    assign grant_id = gnt_q;

    genvar gi;
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel_fsm u_fsm (
            .clk            (clk),
            .rst            (rst),
            .sw_i           (sw[gi]),
            .done_i         (done && (gnt_q == ID_W'(gi))),
            .req_o          (req[gi]),
            .one_shot_o     (one_shot[gi]),
            .level_o        (level[gi])
`ifdef RELEASE_SHOT_EN
            ,
            .release_shot_o (release_shot[gi])
`endif
        );
    end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Bench for debounce_timer_arbiter with N_CH=4, DELAY_CYCLES=4.
// Edge n is the n-th rising clk edge; expectations describe the cycle after it.
module tb_debounce_timer_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] one_shot;
    logic [3:0] level;
    logic       busy;
    logic [1:0] grant_id;
`ifdef RELEASE_SHOT_EN
    logic [3:0] release_shot;
`endif

    debounce_timer_arbiter #(
        .N_CH         (4),
        .DELAY_CYCLES (4),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .one_shot     (one_shot),
        .level        (level),
        .busy         (busy),
        .grant_id     (grant_id)
`ifdef RELEASE_SHOT_EN
        ,
        .release_shot (release_shot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        bit         drv;
        bit         rst_v;
        logic [3:0] sw_v;
        bit         chk;
        logic [3:0] os;
        logic [3:0] lv;
        logic       bsy;
        logic [1:0] gid;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic [3:0] os;
        logic [3:0] lv;
        logic       bsy;
        logic [1:0] gid;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   edge_n;
    int   os_cnt[4];
    int   rel_cnt[4];
    int   glog_id[$];
    int   glog_edge[$];
    logic busy_prev;
    logic [1:0] gid_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        for (int c = 0; c < 4; c++) begin
            if (one_shot[c]) os_cnt[c]++;
`ifdef RELEASE_SHOT_EN
            if (release_shot[c]) rel_cnt[c]++;
`endif
        end
        if (busy && (!busy_prev || grant_id != gid_prev)) begin
            glog_id.push_back(int'(grant_id));
            glog_edge.push_back(edge_n);
        end
        busy_prev = busy;
        gid_prev  = grant_id;
    endtask

    task automatic add_drv(input int e, input bit r, input logic [3:0] s);
        vec_t v;
        v = '{default: '0};
        v.edge_n = e;
        v.drv    = 1'b1;
        v.rst_v  = r;
        v.sw_v   = s;
        vecs.push_back(v);
    endtask

    task automatic add_chk(input int e, input logic [3:0] o, input logic [3:0] l,
                           input logic b, input logic [1:0] g);
        vec_t v;
        v = '{default: '0};
        v.edge_n = e;
        v.chk    = 1'b1;
        v.os     = o;
        v.lv     = l;
        v.bsy    = b;
        v.gid    = g;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t ex;
        int   vi;
        int   last_edge;
        int   os_base[4];
        checks    = 0;
        errors    = 0;
        edge_n    = 0;
        busy_prev = 1'b0;
        gid_prev  = '0;
        for (int c = 0; c < 4; c++) begin
            os_cnt[c]  = 0;
            rel_cnt[c] = 0;
        end
        rst = 1'b1;
        sw  = 4'b0000;

        // Reset, then idle.
        add_drv(1, 1, 4'b0000);
        add_chk(2, 4'b0000, 4'b0000, 0, 0);
        add_drv(3, 0, 4'b0000);
        for (int e = 3; e <= 22; e++) add_chk(e, 4'b0000, 4'b0000, 0, 0);
        // Channels 0, 2, 3 press together: grants 0, 2, 3 four edges apart.
        add_drv(24, 0, 4'b1101);
        add_chk(25, 4'b0000, 4'b0000, 0, 0);
        add_chk(26, 4'b1101, 4'b1101, 0, 0);
        add_chk(27, 4'b0000, 4'b1101, 0, 0);
        add_chk(28, 4'b0000, 4'b1101, 1, 0);
        add_chk(31, 4'b0000, 4'b1101, 1, 0);
        add_chk(32, 4'b0000, 4'b1101, 1, 2);
        add_chk(35, 4'b0000, 4'b1101, 1, 2);
        add_chk(36, 4'b0000, 4'b1101, 1, 3);
        add_chk(38, 4'b0000, 4'b1101, 1, 3);
        // One-cycle reset while channel 3 owns the timer at cnt=2.
        add_drv(39, 1, 4'b1101);
        add_chk(39, 4'b0000, 4'b0000, 0, 0);
        add_drv(40, 0, 4'b1101);
        add_chk(40, 4'b0000, 4'b0000, 0, 0);
        add_chk(41, 4'b0000, 4'b0000, 0, 0);
        add_chk(42, 4'b1101, 4'b1101, 0, 0);
        add_chk(43, 4'b0000, 4'b1101, 0, 0);
        add_chk(44, 4'b0000, 4'b1101, 1, 0);
        add_chk(48, 4'b0000, 4'b1101, 1, 2);
        add_chk(52, 4'b0000, 4'b1101, 1, 3);
        add_chk(55, 4'b0000, 4'b1101, 1, 3);
        add_chk(56, 4'b0000, 4'b1101, 0, 0);
        // Channel 1 press with chatter during its lockout.
        add_drv(58, 0, 4'b1111);
        add_chk(59, 4'b0000, 4'b1101, 0, 0);
        add_chk(60, 4'b0010, 4'b1111, 0, 0);
        add_chk(61, 4'b0000, 4'b1111, 0, 0);
        add_drv(62, 0, 4'b1101);
        add_chk(62, 4'b0000, 4'b1111, 1, 1);
        add_drv(63, 0, 4'b1111);
        add_drv(64, 0, 4'b1101);
        add_drv(65, 0, 4'b1111);
        add_chk(65, 4'b0000, 4'b1111, 1, 1);
        add_chk(66, 4'b0000, 4'b1111, 0, 0);
        add_chk(70, 4'b0000, 4'b1111, 0, 0);
        // Channel 2 release: WAIT_R lockout of four cycles.
        add_drv(72, 0, 4'b1011);
        add_chk(73, 4'b0000, 4'b1111, 0, 0);
        add_chk(74, 4'b0000, 4'b1011, 0, 0);
        add_chk(75, 4'b0000, 4'b1011, 1, 2);
        add_chk(78, 4'b0000, 4'b1011, 1, 2);
        add_chk(79, 4'b0000, 4'b1011, 0, 0);
        add_chk(80, 4'b0000, 4'b1011, 0, 0);

        last_edge = vecs[vecs.size() - 1].edge_n;
        vi = 0;
        for (int e = 1; e <= last_edge; e++) begin
            while (vi < vecs.size() && vecs[vi].edge_n == e) begin
                if (vecs[vi].drv) begin
                    rst = vecs[vi].rst_v;
                    sw  = vecs[vi].sw_v;
                end
                if (vecs[vi].chk) begin
                    ex.edge_n = e;
                    ex.os     = vecs[vi].os;
                    ex.lv     = vecs[vi].lv;
                    ex.bsy    = vecs[vi].bsy;
                    ex.gid    = vecs[vi].gid;
                    exp_q.push_back(ex);
                end
                vi++;
            end
            tick();
            while (exp_q.size() > 0 && exp_q[0].edge_n == edge_n) begin
                ex = exp_q.pop_front();
                $display("edge %0d sw=%b one_shot=%b level=%b busy=%b grant_id=%0d",
                         edge_n, sw, one_shot, level, busy, grant_id);
                check("one_shot", 32'(one_shot), 32'(ex.os));
                check("level", 32'(level), 32'(ex.lv));
                check("busy", 32'(busy), 32'(ex.bsy));
                check("grant_id", 32'(grant_id), 32'(ex.gid));
            end
        end

        check("pulses_ch0", os_cnt[0], 2);
        check("pulses_ch1", os_cnt[1], 1);
        check("pulses_ch2", os_cnt[2], 2);
        check("pulses_ch3", os_cnt[3], 2);
`ifdef RELEASE_SHOT_EN
        check("release_ch2", rel_cnt[2], 1);
        check("release_ch0", rel_cnt[0], 0);
`endif

        // Release everything; all channels must settle back to IDLE.
        sw = 4'b0000;
        repeat (20) tick();
        $display("edge %0d all released level=%b busy=%b", edge_n, level, busy);
        check("released_level", 32'(level), 32'h0);
        check("released_busy", 32'(busy), 32'h0);
        check("released_no_pulse", os_cnt[0] + os_cnt[1] + os_cnt[2] + os_cnt[3], 7);
`ifdef RELEASE_SHOT_EN
        for (int c = 0; c < 4; c++) check("release_once", rel_cnt[c], 1);
`endif

        // Hold all switches: one pulse each, grants in round-robin order 2,3,0,1.
        for (int c = 0; c < 4; c++) os_base[c] = os_cnt[c];
        glog_id.delete();
        glog_edge.delete();
        sw = 4'b1111;
        repeat (100) tick();
        $display("edge %0d held all: grants logged %0d level=%b", edge_n, glog_id.size(), level);
        for (int c = 0; c < 4; c++) check("hold_one_pulse", os_cnt[c] - os_base[c], 1);
        check("hold_grant_count", glog_id.size(), 4);
        if (glog_id.size() == 4) begin
            check("hold_grant0", glog_id[0], 2);
            check("hold_grant1", glog_id[1], 3);
            check("hold_grant2", glog_id[2], 0);
            check("hold_grant3", glog_id[3], 1);
            for (int i = 1; i < 4; i++)
                check("hold_grant_spacing", glog_edge[i] - glog_edge[i-1], 4);
        end
        check("hold_level", 32'(level), 32'hF);
        check("hold_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
